// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester handshakes and the data-memory port shared by dm_arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface dm_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [31:0]       addr0;
  logic [DATA_W-1:0] wd0;
  logic              gnt0;
  logic              done0;
  logic [DATA_W-1:0] rd0;
  logic              err0;

  logic              req1;
  logic              we1;
  logic [31:0]       addr1;
  logic [DATA_W-1:0] wd1;
  logic              gnt1;
  logic              done1;
  logic [DATA_W-1:0] rd1;
  logic              err1;

  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_rd,
    output gnt0, done0, rd0, err0, gnt1, done1, rd1, err1,
    output mem_we, mem_addr, mem_wd
  );

  modport master (
    output req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_rd,
    input  gnt0, done0, rd0, err0, gnt1, done1, rd1, err1,
    input  mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: gnt -> access -> done, 2 cycles/transaction.
// Define DM_ARB_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module dm_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
  parameter int          DATA_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  dm_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              lat_we_q;
  logic [31:0]       lat_addr_q;
  logic [DATA_W-1:0] lat_wd_q;
  logic              owner_q;
  logic              err_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;
`ifndef DM_ARB_PRIO_EN
  logic              last_q;
`endif

  logic [1:0]        req_w;
  logic              winner;
  logic              grant;
  logic              legal;
  logic              done;

  assign req_w = {bus.req1, bus.req0};

  // Winner selection; only meaningful when grant is asserted.
  always_comb begin
    winner = 1'b0;
`ifdef DM_ARB_PRIO_EN
    winner = ~req_w[0];
`else
    if (req_w == 2'b11) begin
      winner = ~last_q;
    end else begin
      winner = ~req_w[0];
    end
`endif
  end

  assign grant = ((state_q == IDLE) || (state_q == RESP)) && (|req_w) && !reset;
  assign legal = (lat_addr_q[1:0] == 2'b00) && (lat_addr_q < ADDR_LIMIT);
  assign done  = (state_q == RESP) && !reset;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = grant ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_we_q   <= 1'b0;
      lat_addr_q <= '0;
      lat_wd_q   <= '0;
      owner_q    <= 1'b0;
      err_q      <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
`ifndef DM_ARB_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q    <= winner;
        lat_we_q   <= winner ? bus.we1   : bus.we0;
        lat_addr_q <= winner ? bus.addr1 : bus.addr0;
        lat_wd_q   <= winner ? bus.wd1   : bus.wd0;
`ifndef DM_ARB_PRIO_EN
        last_q     <= winner;
`endif
      end
      if (state_q == ACCESS) begin
        err_q <= !legal;
        // Illegal reads leave the owner's read register untouched.
        if (!lat_we_q && legal) begin
          if (owner_q) begin
            rd1_q <= bus.mem_rd;
          end else begin
            rd0_q <= bus.mem_rd;
          end
        end
      end
    end
  end

  assign bus.gnt0  = grant && !winner;
  assign bus.gnt1  = grant && winner;
  assign bus.done0 = done && !owner_q;
  assign bus.done1 = done && owner_q;
  assign bus.err0  = done && !owner_q && err_q;
  assign bus.err1  = done && owner_q && err_q;
  assign bus.rd0   = rd0_q;
  assign bus.rd1   = rd1_q;

  // Address/data come straight from the latch, so they hold between accesses.
  assign bus.mem_we   = (state_q == ACCESS) && lat_we_q && legal && !reset;
  assign bus.mem_addr = lat_addr_q;
  assign bus.mem_wd   = lat_wd_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: per-cycle directed vector table, then randomized traffic checked
// against a transaction-level model (serialized accesses, round-robin or priority pick).
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_arbiter_if #(.DATA_W(32)) bus ();

  dm_arbiter #(.ADDR_LIMIT(32'h0000_4000), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Data RAM: combinational read, synchronous write.
  logic [31:0] ram [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h1000_0000 + i;
  end
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[13:2]] <= bus.mem_wd;
  end
  assign bus.mem_rd = ram[bus.mem_addr[13:2]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, dn0, dn1, e0, e1, mwe;
    logic        ca;
    logic [31:0] maddr;
    logic        cr;
    logic [31:0] x0, x1;
  } vec_t;

  function automatic vec_t V(
    input logic rst, input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic g0, input logic g1, input logic dn0, input logic dn1,
    input logic e0, input logic e1, input logic mwe,
    input logic ca, input logic [31:0] maddr, input logic cr, input logic [31:0] x0, input logic [31:0] x1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.dn0 = dn0; v.dn1 = dn1; v.e0 = e0; v.e1 = e1; v.mwe = mwe;
    v.ca = ca; v.maddr = maddr; v.cr = cr; v.x0 = x0; v.x1 = x1;
    return v;
  endfunction

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] P0 = 32'h1000_0000;
  localparam logic [31:0] P8 = 32'h1000_0008;

  vec_t vt [27];

  // Model state for the randomized phase
  logic [31:0] mm [4096];
  logic [31:0] rdv [2];
  logic        last_m;
  int          next_free;
  logic        rq [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] rdat [2];
  logic        gseen [2];
  logic        dvalid [4];
  logic        dport [4];
  logic        derr [4];
  logic        dupd [4];
  logic [31:0] dval [4];
  logic        wexp [4];

  function automatic logic [31:0] rand_addr();
    int idx;
    int kind;
    idx  = $urandom_range(0, 15);
    kind = $urandom_range(0, 9);
    if (kind == 0) return idx * 4 + $urandom_range(1, 3);
    if (kind == 1) return 32'h4000 + idx * 4;
    if (kind == 2) return 32'h3FFC;
    return idx * 4;
  endfunction

  initial begin
    int c;
    int w;
    int slot;
    logic [31:0] a;
    logic lg;
    logic [1:0] eg;

    reset = 1'b1;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wd0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wd1 = 0;

    //        rst r0 w0 a0       d0            r1 w1 a1      d1            g0 g1 dn0 dn1 e0 e1 mwe ca maddr    cr x0  x1
    vt[0]  = V(1, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 0,       1, 0,  0);
    vt[1]  = V(0, 1, 1, 32'h10,  DB,           0, 0, 0,      0,            1, 0, 0, 0, 0, 0, 0,  1, 0,       1, 0,  0);
    vt[2]  = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 1,  1, 32'h10,  1, 0,  0);
    vt[3]  = V(0, 0, 0, 0,       0,            1, 0, 32'h10, 0,            0, 1, 1, 0, 0, 0, 0,  1, 32'h10,  1, 0,  0);
    vt[4]  = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 32'h10,  1, 0,  0);
    vt[5]  = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 1, 0, 0, 0,  0, 0,       1, 0,  DB);
    vt[6]  = V(0, 1, 1, 32'h12,  32'h11111111, 0, 0, 0,      0,            1, 0, 0, 0, 0, 0, 0,  0, 0,       1, 0,  DB);
    vt[7]  = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 32'h12,  1, 0,  DB);
    vt[8]  = V(0, 1, 1, 32'h4000,32'h22222222, 0, 0, 0,      0,            1, 0, 1, 0, 1, 0, 0,  0, 0,       1, 0,  DB);
    vt[9]  = V(0, 1, 0, 32'h10,  0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 32'h4000,1, 0,  DB);
    vt[10] = V(0, 1, 0, 32'h10,  0,            0, 0, 0,      0,            1, 0, 1, 0, 1, 0, 0,  0, 0,       1, 0,  DB);
    vt[11] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 32'h10,  1, 0,  DB);
    vt[12] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 1, 0, 0, 0, 0,  0, 0,       1, DB, DB);
    vt[13] = V(0, 0, 0, 0,       0,            1, 1, 32'h20, 32'h33333333, 0, 1, 0, 0, 0, 0, 0,  0, 0,       1, DB, DB);
    vt[14] = V(1, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  0, 0,       0, 0,  0);
    vt[15] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 0,       1, 0,  0);
    vt[16] = V(0, 0, 0, 0,       0,            1, 0, 32'h20, 0,            0, 1, 0, 0, 0, 0, 0,  1, 0,       1, 0,  0);
    vt[17] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 32'h20,  1, 0,  0);
    vt[18] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 1, 0, 0, 0,  0, 0,       1, 0,  P8);
    vt[19] = V(0, 1, 0, 0,       0,            1, 0, 0,      0,            1, 0, 0, 0, 0, 0, 0,  0, 0,       1, 0,  P8);
    vt[20] = V(0, 1, 0, 0,       0,            1, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 0,       1, 0,  P8);
`ifdef DM_ARB_PRIO_EN
    vt[21] = V(0, 1, 0, 0,       0,            1, 0, 0,      0,            1, 0, 1, 0, 0, 0, 0,  0, 0,       1, P0, P8);
    vt[23] = V(0, 1, 0, 0,       0,            1, 0, 0,      0,            1, 0, 1, 0, 0, 0, 0,  0, 0,       1, P0, P8);
    vt[24] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 0,       1, P0, P8);
    vt[25] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 1, 0, 0, 0, 0,  0, 0,       1, P0, P8);
    vt[26] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  0, 0,       1, P0, P8);
`else
    vt[21] = V(0, 1, 0, 0,       0,            1, 0, 0,      0,            0, 1, 1, 0, 0, 0, 0,  0, 0,       1, P0, P8);
    vt[23] = V(0, 1, 0, 0,       0,            1, 0, 0,      0,            1, 0, 0, 1, 0, 0, 0,  0, 0,       1, P0, P0);
    vt[24] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 0,       1, P0, P0);
    vt[25] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 1, 0, 0, 0, 0,  0, 0,       1, P0, P0);
    vt[26] = V(0, 0, 0, 0,       0,            0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  0, 0,       1, P0, P0);
`endif
    vt[22] = V(0, 1, 0, 0,       0,            1, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0,  1, 0,       1, P0, P8);

    repeat (2) @(posedge clk);
    #1;

    // Directed phase: one table row per clock cycle.
    for (int i = 0; i < 27; i++) begin
      cyc = i;
      reset = vt[i].rst;
      bus.req0 = vt[i].r0; bus.we0 = vt[i].w0; bus.addr0 = vt[i].a0; bus.wd0 = vt[i].d0;
      bus.req1 = vt[i].r1; bus.we1 = vt[i].w1; bus.addr1 = vt[i].a1; bus.wd1 = vt[i].d1;
      @(negedge clk);
      chk("gnt0", 32'(bus.gnt0), 32'(vt[i].g0));
      chk("gnt1", 32'(bus.gnt1), 32'(vt[i].g1));
      chk("done0", 32'(bus.done0), 32'(vt[i].dn0));
      chk("done1", 32'(bus.done1), 32'(vt[i].dn1));
      chk("err0", 32'(bus.err0), 32'(vt[i].e0));
      chk("err1", 32'(bus.err1), 32'(vt[i].e1));
      chk("mem_we", 32'(bus.mem_we), 32'(vt[i].mwe));
      if (vt[i].ca) chk("mem_addr", bus.mem_addr, vt[i].maddr);
      if (vt[i].cr) begin
        chk("rd0", bus.rd0, vt[i].x0);
        chk("rd1", bus.rd1, vt[i].x1);
      end
      $display("directed cycle %0d: gnt=%b%b done=%b%b err=%b%b mem_we=%b addr=%h rd0=%h rd1=%h",
               i, bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.err1, bus.err0,
               bus.mem_we, bus.mem_addr, bus.rd0, bus.rd1);
      @(posedge clk);
      #1;
    end

    // Randomized phase: restart from reset; model memory mirrors the directed write.
    for (int i = 0; i < 4096; i++) mm[i] = 32'h1000_0000 + i;
    mm[4] = DB;
    reset = 1'b1;
    bus.req0 = 0; bus.req1 = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_m = 1'b1;
    next_free = 0;
    for (int p = 0; p < 2; p++) begin
      rdv[p] = 0; rq[p] = 0; rw[p] = 0; ra[p] = 0; rdat[p] = 0; gseen[p] = 0;
    end
    for (int s = 0; s < 4; s++) begin
      dvalid[s] = 0; dport[s] = 0; derr[s] = 0; dupd[s] = 0; dval[s] = 0; wexp[s] = 0;
    end

    for (c = 0; c < 3000; c++) begin
      cyc = 100 + c;
      for (int p = 0; p < 2; p++) begin
        if (!(rq[p] && !gseen[p])) begin
          if ($urandom_range(0, 9) < 6) begin
            rq[p] = 1; rw[p] = $urandom_range(0, 1); ra[p] = rand_addr(); rdat[p] = $urandom;
          end else begin
            rq[p] = 0;
          end
        end
      end
      bus.req0 = rq[0]; bus.we0 = rw[0]; bus.addr0 = ra[0]; bus.wd0 = rdat[0];
      bus.req1 = rq[1]; bus.we1 = rw[1]; bus.addr1 = ra[1]; bus.wd1 = rdat[1];
      @(negedge clk);

      // One transaction at a time: a new grant is possible two cycles after the last one.
      eg = 2'b00;
      if (c >= next_free && (rq[0] || rq[1])) begin
`ifdef DM_ARB_PRIO_EN
        w = rq[0] ? 0 : 1;
`else
        if (rq[0] && rq[1]) w = (last_m == 1'b1) ? 0 : 1;
        else w = rq[0] ? 0 : 1;
`endif
        last_m = w[0];
        eg[w] = 1'b1;
        next_free = c + 2;
        a = ra[w];
        lg = (a % 4 == 0) && (a < 16384);
        slot = (c + 2) % 4;
        dvalid[slot] = 1; dport[slot] = w[0]; derr[slot] = !lg;
        dupd[slot] = !rw[w] && lg;
        dval[slot] = lg ? mm[a / 4] : 32'h0;
        if (rw[w] && lg) mm[a / 4] = rdat[w];
        wexp[(c + 1) % 4] = rw[w] && lg;
      end
      slot = c % 4;
      if (dvalid[slot] && dupd[slot]) rdv[dport[slot]] = dval[slot];

      chk("rnd_gnt0", 32'(bus.gnt0), 32'(eg[0]));
      chk("rnd_gnt1", 32'(bus.gnt1), 32'(eg[1]));
      chk("rnd_done0", 32'(bus.done0), 32'(dvalid[slot] && !dport[slot]));
      chk("rnd_done1", 32'(bus.done1), 32'(dvalid[slot] && dport[slot]));
      chk("rnd_err0", 32'(bus.err0), 32'(dvalid[slot] && !dport[slot] && derr[slot]));
      chk("rnd_err1", 32'(bus.err1), 32'(dvalid[slot] && dport[slot] && derr[slot]));
      chk("rnd_mem_we", 32'(bus.mem_we), 32'(wexp[slot]));
      chk("rnd_rd0", bus.rd0, rdv[0]);
      chk("rnd_rd1", bus.rd1, rdv[1]);
      if (eg != 2'b00)
        $display("random cycle %0d: grant port %0d we=%b addr=%h", c, w, rw[w], ra[w]);

      gseen[0] = bus.gnt0;
      gseen[1] = bus.gnt1;
      dvalid[slot] = 0;
      wexp[slot] = 0;
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (word-addressed RAM, 32-bit, combinational read, synchronous write) between two requesters.
  - Port 0 is the CPU MEM stage.
  - Port 1 is a DMA/debug loader.
- Each requester uses a req/gnt/done handshake.
- The arbiter latches the winning request, drives the memory port for exactly one cycle, then returns read data and status.
- Sits between the pipeline/DMA and the data memory; it is the only driver of the memory's WE/addr/WD.

Parameters:
- ADDR_LIMIT, 32'h0000_4000, exclusive upper bound of legal byte addresses (4096 words).
- DATA_W, 32, data width of wd/rd buses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held until gnt0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  32  port 0 byte address
- wd0  in  DATA_W  port 0 write data
- gnt0  out  1  one-cycle pulse: port 0 request accepted
- done0  out  1  one-cycle pulse: port 0 transaction complete
- rd0  out  DATA_W  port 0 read data, valid with done0, held otherwise
- err0  out  1  valid with done0: address misaligned or out of range
- req1/we1/addr1/wd1/gnt1/done1/rd1/err1  same as port 0, for port 1
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_wd  out  DATA_W  memory write data
- mem_rd  in  DATA_W  memory read data (combinational from mem_addr)

Behaviour:
- Reset is synchronous and active-high on clk. On reset:
  - All outputs are 0 (gnt*, done*, rd*, err*, mem_we, mem_addr, mem_wd).
  - State goes to IDLE and last_served = 1, so port 0 wins the first tie.
  - No memory write occurs in a reset cycle.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any req is high, pick a winner, pulse its gnt, and latch {we, addr, wd, owner} into internal registers. Next state is ACCESS; otherwise stay in IDLE.
  - ACCESS: drive mem_addr/mem_wd from the latched values.
    - mem_we = latched_we AND legal.
    - legal = (addr[1:0]==0) AND (addr < ADDR_LIMIT).
    - At the clock edge, capture mem_rd into the owner's rd register (reads only; legal reads only) and capture err = !legal. Next state is RESP.
  - RESP: pulse done and present err for the owner. In the same cycle arbitrate exactly as in IDLE.
    - If a req is high: issue gnt, latch, and go to ACCESS.
    - Otherwise go to IDLE.
- Latency: gnt in cycle N, memory access in N+1, done in N+2. Sustained throughput is one transaction per 2 cycles.
- Arbitration is round-robin.
  - Single requester: granted.
  - Both requesting: grant the port != last_served.
  - last_served updates on every gnt.
- mem_we is high only in ACCESS and never more than one cycle per transaction. mem_addr/mem_wd hold their last driven values outside ACCESS.
- Illegal access:
  - Writes are suppressed.
  - For reads, rd is not updated (keeps its previous value).
  - err = 1 with done.
  - The transaction is still granted and completed.
- Requesters may change addr/wd/we freely after gnt, because the arbiter uses latched copies.
- A req still high in the done cycle is treated as a new request.
- Reset mid-operation: the in-flight transaction is dropped with no done, and a latched write not yet in ACCESS never reaches memory.
- Reset asserted during ACCESS: mem_we is forced 0.

Optional Feature:
- Macro DM_ARB_PRIO_EN.
- When defined: fixed priority, port 0 always wins when both request; last_served is unused.
- When undefined: round-robin as above.
- Handshake and latency are identical in both builds.

Test Plan:
- Port 0 write, reset released, req0=1 we0=1 addr0=0x10 wd0=0xDEADBEEF: gnt0 at cycle N, mem_we=1 and mem_addr=0x10 at N+1, done0 at N+2 with err0=0.
- Then port 1 read of addr1=0x10: done1 two cycles after gnt1, rd1=0xDEADBEEF, err1=0.
- req0 and req1 high together from reset, held continuously: grants alternate 0,1,0,1, one gnt every 2 cycles. With DM_ARB_PRIO_EN defined: only port 0 granted while req0 stays high.
- Port 0 write to addr0=0x12 (misaligned), then addr0=0x4000 (out of range): mem_we stays 0 in both ACCESS cycles, done0 with err0=1; a subsequent read of 0x10 still returns prior data.
- reset asserted in the ACCESS cycle of a port 1 write to 0x20: mem_we=0, no done1, all outputs 0 next cycle; a read of 0x20 afterwards returns the pre-reset value.
- Back-to-back from port 0: done0 and the next gnt0 occur in the same RESP cycle; the second transaction's mem access follows immediately.
